// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and memory-wait controller for a 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait FSM with timeout. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       idex_MemRead,
   input  logic [4:0] idex_rd,
   input  logic       exmem_Branch,
   input  logic       exmem_Zero,
   input  logic       exmem_Is_Greater,
   input  logic [3:0] exmem_funct,
   input  logic       exmem_MemRead,
   input  logic       exmem_MemWrite,
   input  logic       dmem_ready,
   output logic       PCWrite,
   output logic       IFID_Write,
   output logic       PCSrc,
   output logic       IFID_Flush,
   output logic       IDEX_Flush,
   output logic       EXMEM_Flush,
   output logic       Stall_all,
   output logic       dmem_req,
   output logic [1:0] state,
   output logic       timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic take;
   logic mem;
   logic luse;

   // Bit 3 of funct is a don't-care for branch decode.
   always_comb begin
      take = 1'b0;
      if (exmem_Branch) begin
         casez (exmem_funct)
            4'b?000: take = exmem_Zero;
            4'b?001: take = !exmem_Zero;
            4'b?100: take = !exmem_Is_Greater && !exmem_Zero;
            4'b?101: take = exmem_Is_Greater || exmem_Zero;
            default: take = 1'b0;
         endcase
      end
   end

   always_comb begin
      mem  = exmem_MemRead || exmem_MemWrite;
      luse = idex_MemRead && (idex_rd != 5'd0) &&
             ((idex_rd == id_rs1) || (idex_rd == id_rs2));
   end

   always_comb begin
      PCWrite       = 1'b1;
      IFID_Write    = 1'b1;
      PCSrc         = 1'b0;
      IFID_Flush    = 1'b0;
      IDEX_Flush    = 1'b0;
      EXMEM_Flush   = 1'b0;
      Stall_all     = 1'b0;
      dmem_req      = 1'b0;
      state_d       = state_q;
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         RUN: begin
            dmem_req = mem;
            cnt_d    = '0;
            if (mem && !dmem_ready) begin
               Stall_all  = 1'b1;
               PCWrite    = 1'b0;
               IFID_Write = 1'b0;
               state_d    = MEM_WAIT;
            end else if (take) begin
               PCSrc       = 1'b1;
               IFID_Flush  = 1'b1;
               IDEX_Flush  = 1'b1;
               EXMEM_Flush = 1'b1;
            end else if (luse) begin
               PCWrite    = 1'b0;
               IFID_Write = 1'b0;
               IDEX_Flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            dmem_req   = 1'b1;
            Stall_all  = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            if (dmem_ready) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d       = ERROR;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ERROR: begin
            Stall_all  = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      if (!rst_n) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         PCSrc       = 1'b0;
         Stall_all   = 1'b0;
         dmem_req    = 1'b0;
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         EXMEM_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign state       = state_q;
   assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!PCWrite) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      if ((state_q == RUN) && take) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4); perf counters checked under HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       idex_mr;
      logic [4:0] idex_rd;
      logic       br;
      logic       zero;
      logic       gt;
      logic [3:0] funct;
      logic       mr;
      logic       mw;
      logic       rdy;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, idex_rd;
   logic       idex_MemRead;
   logic       exmem_Branch, exmem_Zero, exmem_Is_Greater;
   logic [3:0] exmem_funct;
   logic       exmem_MemRead, exmem_MemWrite, dmem_ready;
   logic       PCWrite, IFID_Write, PCSrc, IFID_Flush, IDEX_Flush, EXMEM_Flush;
   logic       Stall_all, dmem_req, timeout_err;
   logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count, flush_count;
`endif

   int n_run  = 0;
   int n_fail = 0;
   logic [10:0] sb[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
      .exmem_Branch(exmem_Branch), .exmem_Zero(exmem_Zero),
      .exmem_Is_Greater(exmem_Is_Greater), .exmem_funct(exmem_funct),
      .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
      .dmem_ready(dmem_ready),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .PCSrc(PCSrc),
      .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
      .Stall_all(Stall_all), .dmem_req(dmem_req),
      .state(state), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   // Expected vector: {state, err, PCWrite, IFID_Write, PCSrc, IFID_Fl, IDEX_Fl, EXMEM_Fl, Stall_all, dmem_req}
   function automatic logic [10:0] ev(input logic [1:0] st, input logic err, input logic pcw,
                                      input logic ifw, input logic src, input logic f1,
                                      input logic f2, input logic f3, input logic stall,
                                      input logic req);
      return {st, err, pcw, ifw, src, f1, f2, f3, stall, req};
   endfunction

   function automatic logic [10:0] obs();
      return {state, timeout_err, PCWrite, IFID_Write, PCSrc, IFID_Flush, IDEX_Flush,
              EXMEM_Flush, Stall_all, dmem_req};
   endfunction

   localparam stim_t IDLE = '{rst_n: 1'b1, rs1: 5'd1, rs2: 5'd2, idex_mr: 1'b0, idex_rd: 5'd0,
                              br: 1'b0, zero: 1'b0, gt: 1'b0, funct: 4'd0,
                              mr: 1'b0, mw: 1'b0, rdy: 1'b0};

   logic [10:0] RUN_OK, LU, TK, MS0, MW, ER, MRDY;

   task automatic apply(input stim_t s, input logic [10:0] e);
      rst_n            = s.rst_n;
      id_rs1           = s.rs1;
      id_rs2           = s.rs2;
      idex_MemRead     = s.idex_mr;
      idex_rd          = s.idex_rd;
      exmem_Branch     = s.br;
      exmem_Zero       = s.zero;
      exmem_Is_Greater = s.gt;
      exmem_funct      = s.funct;
      exmem_MemRead    = s.mr;
      exmem_MemWrite   = s.mw;
      dmem_ready       = s.rdy;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.rst_n = 1'b0;
      st.push_back(s); ex.push_back(ev(2'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      st.push_back(s); ex.push_back(ev(2'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.idex_mr = 1; s.idex_rd = 5'd5; s.rs2 = 5'd5;
      st.push_back(s); ex.push_back(LU);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      s = IDLE; s.idex_mr = 1; s.idex_rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0;
      st.push_back(s); ex.push_back(RUN_OK);
      s = IDLE; s.idex_mr = 1; s.idex_rd = 5'd7; s.rs1 = 5'd7;
      st.push_back(s); ex.push_back(LU);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      s = IDLE; s.idex_mr = 0; s.idex_rd = 5'd5; s.rs1 = 5'd5;
      st.push_back(s); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      // {funct, zero, gt, br, taken}
      logic [7:0] tbl[$] = '{
         {4'b0101, 1'b0, 1'b1, 1'b1, 1'b1}, {4'b0000, 1'b1, 1'b0, 1'b1, 1'b1},
         {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0}, {4'b0001, 1'b0, 1'b0, 1'b1, 1'b1},
         {4'b0001, 1'b1, 1'b0, 1'b1, 1'b0}, {4'b0100, 1'b0, 1'b0, 1'b1, 1'b1},
         {4'b0100, 1'b0, 1'b1, 1'b1, 1'b0}, {4'b0101, 1'b1, 1'b0, 1'b1, 1'b1},
         {4'b0101, 1'b0, 1'b0, 1'b1, 1'b0}, {4'b0010, 1'b1, 1'b1, 1'b1, 1'b0},
         {4'b1000, 1'b1, 1'b0, 1'b1, 1'b1}, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}};
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      logic [7:0] r;
      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         s = IDLE; s.funct = r[7:4]; s.zero = r[3]; s.gt = r[2]; s.br = r[1];
         st.push_back(s); ex.push_back(r[0] ? TK : RUN_OK);
      end
      s = IDLE; s.br = 1; s.funct = 4'b0101; s.gt = 1;
      s.idex_mr = 1; s.idex_rd = 5'd5; s.rs2 = 5'd5;
      st.push_back(s); ex.push_back(TK);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL branch[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_access();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.mw = 1; s.rdy = 1;
      st.push_back(s); ex.push_back(MRDY);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      s = IDLE; s.mr = 1;
      st.push_back(s); ex.push_back(MS0);
      st.push_back(s); ex.push_back(MW);
      st.push_back(s); ex.push_back(MW);
      s.rdy = 1; s.br = 1; s.funct = 4'b0000; s.zero = 1;
      s.idex_mr = 1; s.idex_rd = 5'd2;
      st.push_back(s); ex.push_back(MW);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL mem_access[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.mr = 1;
      st.push_back(s); ex.push_back(MS0);
      st.push_back(s); ex.push_back(MW);
      st.push_back(s); ex.push_back(MW);
      s.rst_n = 0;
      st.push_back(s); ex.push_back(ev(2'd1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset_mid_wait[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout_boundary();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.mr = 1;
      st.push_back(s); ex.push_back(MS0);
      for (int k = 0; k < 4; k++) begin
         st.push_back(s); ex.push_back(MW);
      end
      s.rdy = 1;
      st.push_back(s); ex.push_back(MW);
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL timeout_boundary[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s;
      s = IDLE; s.mr = 1;
      st.push_back(s); ex.push_back(MS0);
      for (int k = 0; k < 5; k++) begin
         st.push_back(s); ex.push_back(MW);
      end
      st.push_back(IDLE); ex.push_back(ER);
      s.rdy = 1;
      st.push_back(s); ex.push_back(ER);
      s = IDLE; s.br = 1; s.zero = 1;
      st.push_back(s); ex.push_back(ER);
      s = IDLE; s.rst_n = 0;
      st.push_back(s); ex.push_back(ev(2'd2, 1, 0, 0, 0, 1, 1, 1, 0, 0));
      st.push_back(IDLE); ex.push_back(RUN_OK);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL timeout[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_counters();
      stim_t st[$];
      logic [10:0] ex[$];
      logic [10:0] got, want;
      stim_t s, lu_s, tk_s;
      s = IDLE; s.rst_n = 0;
      st.push_back(s); ex.push_back(ev(2'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      lu_s = IDLE; lu_s.idex_mr = 1; lu_s.idex_rd = 5'd3; lu_s.rs1 = 5'd3;
      tk_s = IDLE; tk_s.br = 1; tk_s.funct = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         st.push_back(lu_s); ex.push_back(LU);
         st.push_back(IDLE); ex.push_back(RUN_OK);
      end
      for (int k = 0; k < 2; k++) begin
         st.push_back(tk_s); ex.push_back(TK);
         st.push_back(IDLE); ex.push_back(RUN_OK);
      end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         @(negedge clk);
         want = sb.pop_front(); got = obs(); n_run++;
         if (got !== want) begin
            n_fail++; $display("FAIL perf_seq[%0d]: got %b want %b", i, got, want);
         end
         @(posedge clk); #1;
      end
      n_run++;
      if (stall_count !== 32'd3) begin
         n_fail++; $display("FAIL stall_count: got %0d want 3", stall_count);
      end
      n_run++;
      if (flush_count !== 32'd2) begin
         n_fail++; $display("FAIL flush_count: got %0d want 2", flush_count);
      end
   endtask
`endif

   initial begin
      RUN_OK = ev(2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      LU     = ev(2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      TK     = ev(2'd0, 0, 1, 1, 1, 1, 1, 1, 0, 0);
      MS0    = ev(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      MW     = ev(2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      ER     = ev(2'd2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      MRDY   = ev(2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 1);

      apply(IDLE, '0);
      void'(sb.pop_front());
      rst_n = 1'b0;
      @(posedge clk); #1;

      test_reset();
      test_load_use();
      test_branch();
      test_mem_access();
      test_reset_mid_wait();
      test_timeout_boundary();
      test_timeout();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
